rca_pipe: RTL and testbench



---
 rtl/rca_pkg.sv | 30 +++
 rtl/rca_slice.sv | 37 +++
 rtl/rca_pipe.sv | 161 ++++++++++++++++
 tb/tb_rca_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// ============================================================================
// Module  : rca_pkg
// Brief   : Shared constants, stage record and stage-count helper for rca_pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rca_pkg;

    localparam int c_DEF_WIDTH = 16;
    localparam int c_DEF_SLICE = 4;

    // Per-stage control travelling alongside the data slices.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub_flag;
    } stage_t;

    // Returns 0 for an illegal WIDTH/SLICE pair so the top can refuse to elaborate.
    function automatic int rca_stages(input int width, input int slice);
        if (slice <= 0 || width < slice || (width % slice) != 0) begin
            return 0;
        end
        return width / slice;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rca_slice.sv
// ============================================================================
// Module  : rca_slice
// Brief   : Combinational SLICE-bit ripple adder made of full-adder cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_s,
    output logic             o_cout,
    output logic             o_cmsb
);

    // Carry chain kept in a loop variable so each full-adder cell chains cleanly.
    always_comb begin
        logic w_c;
        w_c    = i_cin;
        o_s    = '0;
        o_cmsb = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                o_cmsb = w_c;
            end
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

`default_nettype wire

// File: rtl/rca_pipe.sv
// ============================================================================
// Module  : rca_pipe
// Brief   : Pipelined ripple-carry adder, one SLICE per stage, valid/ready I/O.
//           Optional subtract/overflow support via `define RCA_PIPE_SUB_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int SLICE = c_DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = rca_stages(WIDTH, SLICE);

    if (STAGES == 0) begin : g_bad_cfg
        $error("rca_pipe: WIDTH must be a non-zero multiple of SLICE");
    end

    logic w_stall;
    logic w_adv;
    logic w_take;

    assign w_stall  = out_valid && !out_ready;
    assign w_adv    = !w_stall;
    assign in_ready = w_adv;
    assign w_take   = in_valid && w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_DONE = SLICE * (k + 1);
        localparam int c_REM  = WIDTH - c_DONE;

        logic [c_REM+SLICE-1:0] w_a_in;
        logic [c_REM+SLICE-1:0] w_b_in;
        logic [SLICE-1:0]       w_b_eff;
        logic [SLICE-1:0]       w_s;
        logic [c_DONE-1:0]      w_s_next;
        logic                   w_vin;
        logic                   w_cin;
        logic                   w_sub;
        logic                   w_cout;
        logic                   w_cmsb;
        logic                   w_unused;
        stage_t                 r_rec;
        logic [c_DONE-1:0]      r_s;

        if (k == 0) begin : g_head
            assign w_a_in   = a;
            assign w_b_in   = b;
            assign w_vin    = w_take;
            assign w_s_next = w_s;
`ifdef RCA_PIPE_SUB_EN
            assign w_sub = sub;
            assign w_cin = sub | cin;
`else
            assign w_sub = 1'b0;
            assign w_cin = cin;
`endif
        end else begin : g_body
            assign w_a_in   = g_stage[k-1].g_skew.r_a;
            assign w_b_in   = g_stage[k-1].g_skew.r_b;
            assign w_vin    = g_stage[k-1].r_rec.valid;
            assign w_cin    = g_stage[k-1].r_rec.carry;
            assign w_sub    = g_stage[k-1].r_rec.sub_flag;
            // Low slices already finished ride underneath the new one.
            assign w_s_next = {w_s, g_stage[k-1].r_s};
        end

`ifdef RCA_PIPE_SUB_EN
        assign w_b_eff = w_b_in[SLICE-1:0] ^ {SLICE{w_sub}};
`else
        assign w_b_eff = w_b_in[SLICE-1:0];
`endif

        rca_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .i_a    (w_a_in[SLICE-1:0]),
            .i_b    (w_b_eff),
            .i_cin  (w_cin),
            .o_s    (w_s),
            .o_cout (w_cout),
            .o_cmsb (w_cmsb)
        );

        // Data only loads with a real beat so the output holds across bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rec <= '0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_rec.valid <= w_vin;
                if (w_vin) begin
                    r_rec.carry    <= w_cout;
                    r_rec.sub_flag <= w_sub;
                    r_s            <= w_s_next;
                end
            end
        end

        if (c_REM > 0) begin : g_skew
            logic [c_REM-1:0] r_a;
            logic [c_REM-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_vin) begin
                    r_a <= w_a_in[c_REM+SLICE-1:SLICE];
                    r_b <= w_b_in[c_REM+SLICE-1:SLICE];
                end
            end
        end

        assign w_unused = w_cmsb ^ r_rec.sub_flag;
    end

    assign out_valid = g_stage[STAGES-1].r_rec.valid;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_rec.carry;

`ifdef RCA_PIPE_SUB_EN
    logic r_ovf;

    // Signed overflow is the carry into the MSB disagreeing with the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv && g_stage[STAGES-1].w_vin) begin
            r_ovf <= g_stage[STAGES-1].w_cout ^ g_stage[STAGES-1].w_cmsb;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_sub;

    assign w_unused_sub = sub;
    assign ovf          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rca_pipe.sv
// ============================================================================
// Module  : tb_rca_pipe
// Brief   : Self-checking scoreboard bench for rca_pipe (WIDTH=16, SLICE=4).
//           Subtract cases are exercised when RCA_PIPE_SUB_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rca_pipe;

`ifdef RCA_PIPE_SUB_EN
    localparam bit c_SUB_EN = 1'b1;
`else
    localparam bit c_SUB_EN = 1'b0;
`endif
    localparam int c_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    rca_pipe #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    bit   g_lat    = 1'b1;
    bit   g_rand   = 1'b0;
    bit   accepted = 1'b0;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic s);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] yy;
        logic        c0;
        yy = y;
        c0 = ci;
        if (c_SUB_EN && s) begin
            yy = ~y;
            c0 = 1'b1;
        end
        full  = {1'b0, x} + {1'b0, yy} + {16'd0, c0};
        e.s   = full[15:0];
        e.c   = full[16];
        e.o   = c_SUB_EN ? ((x[15] == yy[15]) && (full[15] != x[15])) : 1'b0;
        e.acc = cyc;
        e.lat = g_lat;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at negedge, score them, record any accept.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1) begin
            n_cmp++;
            assert (q.size() > 0) else begin
                n_bad++;
                $error("FAIL spurious_out: observed out_valid=1 sum=%0h, expected no result", sum);
            end
            if (q.size() > 0) begin
                e = q[0];
                chk("sum", {16'd0, sum}, {16'd0, e.s});
                chk("cout", {31'd0, cout}, {31'd0, e.c});
                chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                if (out_ready) begin
                    e = q.pop_front();
                    if (e.lat) chk("latency", cyc - e.acc, c_LAT);
                end else begin
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
            end
        end
        accepted = in_valid && in_ready && !rst;
        if (accepted) q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
        cyc++;
        if (g_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic s);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            step();
            if (accepted) return;
        end
        n_cmp++;
        assert (accepted) else begin
            n_bad++;
            $error("FAIL send_timeout: observed no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 80 && q.size() > 0; t++) step();
        n_cmp++;
        assert (q.size() == 0) else begin
            n_bad++;
            $error("FAIL drain: observed %0d results pending, expected 0", q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Full carry ripple and slice-boundary carry.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain();
        send(16'h00FF, 16'h0000, 1'b1, 1'b0);
        drain();
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        drain();

        // Back-to-back streaming; latency check implies consecutive outputs.
        for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 32'h1000), 1'b0, 1'b0);
        drain();

        // Backpressure with a full pipe.
        g_lat = 1'b0;
        for (int i = 0; i < 6; i++) send(16'(i * 32'h0111 + 3), 16'h0F0F, 1'(i), 1'b0);
        out_ready = 1'b0;
        a         = 16'hABCD;
        b         = 16'h5432;
        cin       = 1'b1;
        in_valid  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("bp_no_accept", {31'd0, accepted}, 32'd0);
        end
        out_ready = 1'b1;
        send(16'hABCD, 16'h5432, 1'b1, 1'b0);
        send(16'h8001, 16'h7FFF, 1'b0, 1'b0);
        send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
        drain();
        g_lat = 1'b1;

        // Asynchronous reset with beats in flight.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        send(16'h5555, 16'h6666, 1'b0, 1'b0);
        idle(1);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_sum", {16'd0, sum}, 32'd0);
        q.delete();
        in_valid = 1'b1;
        a        = 16'h7777;
        b        = 16'h0001;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(6);
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        drain();

        // Randomised consumer readiness.
        g_lat  = 1'b0;
        g_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain();
        g_rand    = 1'b0;
        out_ready = 1'b1;
        drain();
        g_lat = 1'b1;

`ifdef RCA_PIPE_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h1234, 16'h1234, 1'b1, 1'b1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
